// File: rtl/reg_watch_pkg.sv
// rtl/reg_watch_pkg.sv - state and status encodings shared by the register-watch monitor
package reg_watch_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_e;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_PASS    = 2'd1;
  localparam logic [1:0] ST_FAIL    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  function automatic logic [1:0] status_of(state_e s);
    case (s)
      S_PASS:    return ST_PASS;
      S_FAIL:    return ST_FAIL;
      S_TIMEOUT: return ST_TIMEOUT;
      default:   return ST_RUN;
    endcase
  endfunction

  function automatic logic is_terminal(state_e s);
    return (s == S_PASS) || (s == S_FAIL) || (s == S_TIMEOUT);
  endfunction

endpackage

// File: rtl/reg_watch_if.sv
// rtl/reg_watch_if.sv - register-file writeback tap and retire strobe
interface reg_watch_if #(
  parameter int XLEN = 32
);
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            retire;

  modport master (output wb_en, wb_addr, wb_data, retire);
  modport slave  (input  wb_en, wb_addr, wb_data, retire);
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that holds at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/reg_watch_monitor.sv
// rtl/reg_watch_monitor.sv - register shadows, run counters and PASS/FAIL/TIMEOUT decision
// Define REG_WATCH_DISPLAY_EN to compile in simulation-only trace messages.
module reg_watch_monitor
  import reg_watch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NUM_CH      = 3,
  parameter int WATCH_BASE  = 27,
  parameter int END_REG     = 26,
  parameter int PASS_REG    = 27,
  parameter int TIMEOUT_CYC = 65536,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  reg_watch_if.slave             wb,
  output logic [NUM_CH*XLEN-1:0] ch_value,
  output logic [NUM_CH-1:0]      ch_changed,
  output logic [1:0]             status,
  output logic                   done,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic [CNT_W-1:0]       retire_cnt
);
  state_e     state_q, state_d;
  logic       pass_q;
  logic [1:0] status_q;
  logic       done_q;
  logic       wr_valid, end_wr, timeout_hit;
  logic       cyc_en, ret_en, cnt_clr;

  // x0 is hard-wired zero, so writes to it never count as anything
  assign wr_valid    = wb.wb_en && (wb.wb_addr != 5'd0);
  assign end_wr      = wr_valid && (wb.wb_addr == 5'(END_REG)) && (wb.wb_data == XLEN'(1));
  assign timeout_hit = (cycle_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    cyc_en  = 1'b0;
    ret_en  = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wb.retire) state_d = S_RUN;
      end
      S_RUN: begin
        if (end_wr) begin
          state_d = pass_q ? S_PASS : S_FAIL;
        end else if (timeout_hit) begin
          state_d = S_TIMEOUT;
        end
      end
      default: state_d = state_q;
    endcase
    // counters advance only on edges that land in RUN, so they freeze on the deciding edge
    cyc_en  = (state_q == S_RUN) && (state_d == S_RUN);
    ret_en  = wb.retire && (state_d == S_RUN);
    cnt_clr = (state_q == S_IDLE) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pass_q   <= 1'b0;
      status_q <= ST_RUN;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_of(state_d);
      done_q   <= is_terminal(state_d);
      if (wr_valid && (wb.wb_addr == 5'(PASS_REG))) begin
        pass_q <= (wb.wb_data == XLEN'(1));
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .en  (cyc_en),
    .clr (cnt_clr),
    .cnt (cycle_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_retire_cnt (
    .clk (clk),
    .rst (rst),
    .en  (ret_en),
    .clr (cnt_clr),
    .cnt (retire_cnt)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic            hit;
    logic [XLEN-1:0] sh_q;
    logic            chg_q;

    assign hit = wr_valid && (wb.wb_addr == 5'(WATCH_BASE + i));

    always_ff @(posedge clk) begin
      if (rst) begin
        sh_q  <= '0;
        chg_q <= 1'b0;
      end else begin
        chg_q <= hit && (wb.wb_data != sh_q);
        if (hit) sh_q <= wb.wb_data;
      end
    end

    assign ch_value[i*XLEN +: XLEN] = sh_q;
    assign ch_changed[i]            = chg_q;

`ifdef REG_WATCH_DISPLAY_EN
    always @(posedge clk) begin
      if (chg_q) $display("reg_watch: x%0d = 0x%0h at cycle %0d", WATCH_BASE + i, sh_q, cycle_cnt);
    end
`endif
  end

`ifdef REG_WATCH_DISPLAY_EN
  always @(posedge clk) begin
    if (!rst && (state_q == S_RUN) && (state_d != S_RUN)) begin
      $display("reg_watch: %s cycles=%0d retired=%0d", state_d.name(), cycle_cnt, retire_cnt);
    end
  end
`endif

  assign status = status_q;
  assign done   = done_q;
endmodule

// File: tb/tb_reg_watch_monitor.sv
// tb/tb_reg_watch_monitor.sv - randomized bench for reg_watch_monitor against a behavioural model
module tb_reg_watch_monitor;
  localparam int XLEN   = 32;
  localparam int NUM_CH = 3;
  localparam int TO_CYC = 16;
  localparam int CNT_W  = 32;
  localparam longint unsigned CNT_MAX = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_watch_if #(.XLEN(XLEN)) wbif ();

  logic [NUM_CH*XLEN-1:0] ch_value;
  logic [NUM_CH-1:0]      ch_changed;
  logic [1:0]             status;
  logic                   done;
  logic [CNT_W-1:0]       cycle_cnt;
  logic [CNT_W-1:0]       retire_cnt;

  reg_watch_monitor #(
    .XLEN(XLEN), .NUM_CH(NUM_CH), .WATCH_BASE(27), .END_REG(26),
    .PASS_REG(27), .TIMEOUT_CYC(TO_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb         (wbif),
    .ch_value   (ch_value),
    .ch_changed (ch_changed),
    .status     (status),
    .done       (done),
    .cycle_cnt  (cycle_cnt),
    .retire_cnt (retire_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: outcome 0=idle 1=running 2=pass 3=fail 4=timeout
  int              m_state;
  longint unsigned m_cyc, m_ret;
  logic [31:0]     m_pass;
  logic [31:0]     m_sh [NUM_CH];
  bit              m_chg [NUM_CH];

  function automatic longint unsigned sat_inc(input longint unsigned v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic step(input bit r, input bit we, input logic [4:0] a, input logic [31:0] d, input bit ret);
    bit wr, fin;
    logic [1:0] exp_status;
    rst = r;
    wbif.wb_en = we;
    wbif.wb_addr = a;
    wbif.wb_data = d;
    wbif.retire = ret;
    @(posedge clk);
    if (r) begin
      m_state = 0; m_cyc = 0; m_ret = 0; m_pass = 0;
      for (int i = 0; i < NUM_CH; i++) begin m_sh[i] = 0; m_chg[i] = 0; end
    end else begin
      wr  = we && (a != 0);
      fin = wr && (a == 26) && (d == 1);
      if (m_state == 0) begin
        if (ret) begin m_state = 1; m_ret = 1; end
      end else if (m_state == 1) begin
        if (fin) m_state = (m_pass == 1) ? 2 : 3;
        else if (m_cyc == TO_CYC - 1) m_state = 4;
        else begin
          m_cyc = sat_inc(m_cyc);
          if (ret) m_ret = sat_inc(m_ret);
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        m_chg[i] = 0;
        if (wr && (a == 27 + i)) begin
          m_chg[i] = (d != m_sh[i]);
          m_sh[i]  = d;
        end
      end
      if (wr && (a == 27)) m_pass = d;
    end
    #1;
    exp_status = (m_state < 2) ? 2'd0 : 2'(m_state - 1);
    check("status", status, exp_status);
    check("done", done, m_state >= 2);
    check("cycle_cnt", cycle_cnt, m_cyc);
    check("retire_cnt", retire_cnt, m_ret);
    check("ch_value", ch_value, {m_sh[2], m_sh[1], m_sh[0]});
    check("ch_changed", ch_changed, {m_chg[2], m_chg[1], m_chg[0]});
  endtask

  task automatic nop(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 5'd0, 32'd0, 0);
  endtask

  task automatic restart();
    step(1, 0, 5'd0, 32'd0, 0);
    step(0, 0, 5'd0, 32'd0, 1);
  endtask

  initial begin
    logic [4:0]  ra;
    logic [31:0] rd;
    int          n;
    rst = 1'b1;
    wbif.wb_en = 1'b0; wbif.wb_addr = '0; wbif.wb_data = '0; wbif.retire = 1'b0;

    step(1, 0, 5'd0, 32'd0, 0);
    step(1, 0, 5'd0, 32'd0, 0);
    nop(10);

    step(0, 0, 5'd0, 32'd0, 1);
    step(0, 1, 5'd27, 32'd5, 0);
    step(0, 1, 5'd28, 32'd7, 0);
    step(0, 1, 5'd28, 32'd7, 0);
    step(0, 1, 5'd0, 32'd9, 0);
    nop(1);

    step(0, 1, 5'd27, 32'd1, 1);
    step(0, 1, 5'd26, 32'd1, 1);
    step(0, 1, 5'd27, 32'd0, 1);
    step(0, 1, 5'd26, 32'd1, 1);
    nop(3);

    restart();
    step(0, 1, 5'd27, 32'd0, 0);
    step(0, 1, 5'd26, 32'd2, 1);
    step(0, 1, 5'd26, 32'd1, 0);
    nop(2);

    restart();
    nop(16);
    nop(2);

    restart();
    nop(15);
    step(0, 1, 5'd26, 32'd1, 0);
    nop(2);

    restart();
    step(0, 1, 5'd27, 32'd1, 0);
    nop(14);
    step(0, 1, 5'd26, 32'd1, 1);
    nop(2);

    restart();
    nop(8);
    step(1, 0, 5'd0, 32'd0, 1);
    step(0, 0, 5'd0, 32'd0, 1);
    nop(2);

    repeat (40) begin
      step(1, 0, 5'd0, 32'd0, 0);
      n = $urandom_range(5, 30);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 5))
          0: ra = 5'd0;
          1: ra = 5'd26;
          2: ra = 5'd27;
          3: ra = 5'd28;
          4: ra = 5'd29;
          default: ra = 5'($urandom_range(1, 31));
        endcase
        case ($urandom_range(0, 3))
          0: rd = 32'd0;
          1: rd = 32'd1;
          2: rd = 32'd2;
          default: rd = $urandom;
        endcase
        step($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)), ra, rd, 1'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
